// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR block: CSR addresses, csr_op
// encoding and mstatus bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // The core only implements machine mode, so MPP always returns to M.
  localparam logic [1:0] PRIV_M = 2'b11;

  function automatic logic csr_addr_legal(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/csr_if.sv
// Instruction-side bundle between the core datapath and the CSR block.
// There is no valid/ready handshake: every field is sampled at each rising
// edge, csr_op == NONE / ecall_en == 0 / mret_en == 0 mean "idle", and the
// read-back outputs are combinational from the current CSR state.
interface csr_if #(
  parameter int XLEN = 32
);

  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] src_data;
  logic [XLEN-1:0] pc;
  logic            ecall_en;
  logic [XLEN-1:0] ecall_no;
  logic            mret_en;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  modport master (
    output csr_op, csr_addr, src_data, pc, ecall_en, ecall_no, mret_en,
    input  csr_rdata, csr_illegal, mtvec, mepc
  );

  modport slave (
    input  csr_op, csr_addr, src_data, pc, ecall_en, ecall_no, mret_en,
    output csr_rdata, csr_illegal, mtvec, mepc
  );

endinterface

// File: rtl/csr_rstn_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases two rising
// clock edges after rstn_async goes high.
module csr_rstn_sync (
  input  logic clk,
  input  logic rstn_async,
  output logic rstn_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rstn_sync = sync_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR block (mstatus, mtvec, mepc, mcause) with csrrw/rs/rc,
// ecall trap entry and mret. Define CSR_RSTN_SYNC_EN to synchronize rstn release.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1800)
) (
  input logic  clk,
  input logic  rstn,
  csr_if.slave bus
);

  logic rst_core_n;

`ifdef CSR_RSTN_SYNC_EN
  csr_rstn_sync u_rstn_sync (
    .clk        (clk),
    .rstn_async (rstn),
    .rstn_sync  (rst_core_n)
  );
`else
  assign rst_core_n = rstn;
`endif

  logic [XLEN-1:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
  logic [XLEN-1:0] mstatus_d, mtvec_d, mepc_d, mcause_d;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            addr_legal;
  logic            wr_en;
  csr_op_e         op;

  assign op         = csr_op_e'(bus.csr_op);
  assign addr_legal = csr_addr_legal(bus.csr_addr);
  // An ecall in the same cycle swallows the CSR write entirely.
  assign wr_en      = (op != CSR_OP_NONE) && addr_legal && !bus.ecall_en;

  always_comb begin
    old_val = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: old_val = mstatus_q;
      CSR_MTVEC:   old_val = mtvec_q;
      CSR_MEPC:    old_val = mepc_q;
      CSR_MCAUSE:  old_val = mcause_q;
      default:     old_val = '0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_RW: new_val = bus.src_data;
      CSR_OP_RS: new_val = old_val | bus.src_data;
      CSR_OP_RC: new_val = old_val & ~bus.src_data;
      default:   new_val = old_val;
    endcase
  end

  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;

    if (bus.ecall_en) begin
      mepc_d                                   = bus.pc & ~XLEN'(3);
      mcause_d                                 = bus.ecall_no;
      mstatus_d[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]                   = 1'b0;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    end else begin
      if (wr_en) begin
        case (bus.csr_addr)
          CSR_MSTATUS: mstatus_d = new_val;
          CSR_MTVEC:   mtvec_d   = {new_val[XLEN-1:2], 2'b00};
          CSR_MEPC:    mepc_d    = {new_val[XLEN-1:2], 2'b00};
          CSR_MCAUSE:  mcause_d  = new_val;
          default:     mcause_d  = mcause_q;
        endcase
      end
      // mret overrides only the interrupt-stack fields; a concurrent mstatus
      // write still lands in every other bit.
      if (bus.mret_en) begin
        mstatus_d[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
        mstatus_d[MSTATUS_MPIE]                  = 1'b1;
        mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  assign bus.csr_rdata   = old_val;
  assign bus.csr_illegal = (op != CSR_OP_NONE) && !addr_legal;
  assign bus.mtvec       = mtvec_q;
  assign bus.mepc        = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed plus randomized bench for csr_unit, checked against an
// address-keyed model of the machine-mode CSRs.
module tb_csr_unit;

  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  csr_if #(.XLEN(32)) bus ();

  csr_unit #(
    .XLEN        (32),
    .MSTATUS_RST (32'h0000_1800)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: implemented CSRs keyed by address
  logic [31:0] csr_m [logic [11:0]];

  function automatic logic [31:0] read_m(input logic [11:0] a);
    return csr_m.exists(a) ? csr_m[a] : 32'h0;
  endfunction

  function automatic logic [31:0] write_mask(input logic [11:0] a);
    return (a == 12'h305 || a == 12'h341) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    csr_m.delete();
    csr_m[12'h300] = 32'h0000_1800;
    csr_m[12'h305] = 32'h0;
    csr_m[12'h341] = 32'h0;
    csr_m[12'h342] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.csr_op   = 2'b00;
    bus.csr_addr = 12'h0;
    bus.src_data = 32'h0;
    bus.pc       = 32'h0;
    bus.ecall_en = 1'b0;
    bus.ecall_no = 32'h0;
    bus.mret_en  = 1'b0;
  endtask

  // One instruction cycle: drive, check the combinational read, advance one
  // edge, then check the PC-facing outputs against the updated model.
  task automatic step(input string tag, input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] src, input logic [31:0] pc_v,
                      input logic ecall, input logic [31:0] cause, input logic mret);
    logic [31:0] old_v, new_v, ms;
    bus.csr_op   = op;
    bus.csr_addr = addr;
    bus.src_data = src;
    bus.pc       = pc_v;
    bus.ecall_en = ecall;
    bus.ecall_no = cause;
    bus.mret_en  = mret;
    #1;
    old_v = read_m(addr);
    check({tag, ".rdata"}, bus.csr_rdata, old_v);
    check({tag, ".illegal"}, {31'b0, bus.csr_illegal},
          {31'b0, (op != 2'b00) && !csr_m.exists(addr)});
    ms = read_m(12'h300);
    if (ecall) begin
      csr_m[12'h341] = pc_v & ~32'h3;
      csr_m[12'h342] = cause;
      csr_m[12'h300] = (ms & ~32'h0000_1888) | 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
    end else begin
      if (op != 2'b00 && csr_m.exists(addr)) begin
        case (op)
          2'b01:   new_v = src;
          2'b10:   new_v = old_v | src;
          default: new_v = old_v & ~src;
        endcase
        csr_m[addr] = new_v & write_mask(addr);
      end
      if (mret)
        csr_m[12'h300] = (read_m(12'h300) & ~32'h0000_1888) | 32'h0000_1880 |
                         (ms[7] ? 32'h8 : 32'h0);
    end
    @(posedge clk);
    #1;
    check({tag, ".mtvec"}, bus.mtvec, read_m(12'h305));
    check({tag, ".mepc"}, bus.mepc, read_m(12'h341));
    drive_idle();
  endtask

  task automatic read_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_op   = 2'b00;
    bus.csr_addr = addr;
    #1;
    check(tag, bus.csr_rdata, exp);
    check({tag, ".noillegal"}, {31'b0, bus.csr_illegal}, 32'h0);
  endtask

  task automatic read_all_model(input string tag);
    read_chk({tag, ".mstatus"}, 12'h300, read_m(12'h300));
    read_chk({tag, ".mtvec"},   12'h305, read_m(12'h305));
    read_chk({tag, ".mepc"},    12'h341, read_m(12'h341));
    read_chk({tag, ".mcause"},  12'h342, read_m(12'h342));
  endtask

  task automatic release_reset();
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [11:0] addr_pool [6];

  initial begin
    errors = 0;
    checks = 0;
    rstn   = 1'b0;
    drive_idle();
    model_reset();
    addr_pool[0] = 12'h300;
    addr_pool[1] = 12'h305;
    addr_pool[2] = 12'h341;
    addr_pool[3] = 12'h342;
    addr_pool[4] = 12'h7C0;
    addr_pool[5] = 12'h344;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst.mtvec_out", bus.mtvec, 32'h0);
    check("rst.mepc_out", bus.mepc, 32'h0);
    read_chk("rst.mstatus", 12'h300, 32'h0000_1800);
    read_chk("rst.mtvec", 12'h305, 32'h0);
    read_chk("rst.mepc", 12'h341, 32'h0);
    read_chk("rst.mcause", 12'h342, 32'h0);
    release_reset();

    // read-modify-write on mtvec
    step("mtvec.rw", 2'b01, 12'h305, 32'h8000_0103, 32'h0, 1'b0, 32'h0, 1'b0);
    check("mtvec.rw.val", bus.mtvec, 32'h8000_0100);
    read_chk("mtvec.rs.pre", 12'h305, 32'h8000_0100);
    step("mtvec.rs", 2'b10, 12'h305, 32'h0000_0010, 32'h0, 1'b0, 32'h0, 1'b0);
    check("mtvec.rs.val", bus.mtvec, 32'h8000_0110);
    step("mtvec.rc", 2'b11, 12'h305, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 1'b0);
    check("mtvec.rc.val", bus.mtvec, 32'h8000_0010);
    step("mtvec.rs0", 2'b10, 12'h305, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("mtvec.rs0.val", bus.mtvec, 32'h8000_0010);

    // ecall
    step("ms.set", 2'b01, 12'h300, 32'h0000_1808, 32'h0, 1'b0, 32'h0, 1'b0);
    step("ecall", 2'b00, 12'h0, 32'h0, 32'h8000_0040, 1'b1, 32'hB, 1'b0);
    check("ecall.mepc", bus.mepc, 32'h8000_0040);
    read_chk("ecall.mcause", 12'h342, 32'h0000_000B);
    read_chk("ecall.mstatus", 12'h300, 32'h0000_1880);

    // mret
    step("mret", 2'b00, 12'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    read_chk("mret.mstatus", 12'h300, 32'h0000_1888);
    check("mret.mepc", bus.mepc, 32'h8000_0040);

    // ecall with a simultaneous csrrw to mepc
    step("ecall_rw", 2'b01, 12'h341, 32'h1234, 32'h8000_0123, 1'b1, 32'h8, 1'b0);
    check("ecall_rw.mepc", bus.mepc, 32'h8000_0120);
    read_chk("ecall_rw.mcause", 12'h342, 32'h8);
    read_chk("ecall_rw.mstatus", 12'h300, 32'h0000_1880);

    // illegal address
    step("illegal", 2'b01, 12'h7C0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b0);
    read_all_model("illegal.after");
    read_chk("illegal.rd_none", 12'h7C0, 32'h0);

    // mret with a concurrent mstatus write, then ecall+mret together
    step("mret_wr", 2'b01, 12'h300, 32'hFFFF_0000, 32'h0, 1'b0, 32'h0, 1'b1);
    read_chk("mret_wr.mstatus", 12'h300, 32'hFFFF_1888);
    step("ecall_mret", 2'b00, 12'h0, 32'h0, 32'h8000_0200, 1'b1, 32'h3, 1'b1);
    read_chk("ecall_mret.mstatus", 12'h300, 32'hFFFF_1880);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      logic [11:0] a;
      logic        ec, mr;
      a  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 5)];
      ec = ($urandom_range(0, 9) == 0);
      mr = ($urandom_range(0, 6) == 0);
      step("rand", 2'($urandom), a, $urandom, $urandom, ec, $urandom, mr);
      if (i % 25 == 24) read_all_model("rand.rd");
    end

    // asynchronous reset asserted mid-cycle
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check("arst.mtvec_out", bus.mtvec, 32'h0);
    check("arst.mepc_out", bus.mepc, 32'h0);
    read_all_model("arst");
    read_chk("arst.mstatus_abs", 12'h300, 32'h0000_1800);
    @(negedge clk);
    release_reset();
    step("post_rst", 2'b01, 12'h341, 32'hABCD_EF07, 32'h0, 1'b0, 32'h0, 1'b0);
    check("post_rst.mepc", bus.mepc, 32'hABCD_EF04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
